// File: rtl/adc_pkg.sv
// adc_pkg: shared scan-sequencer state enum, clog2 width helper (min 1) and channel-to-device mapping (cs = ch/CH_PER_DEV, ch_sel = ch%CH_PER_DEV)
package adc_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, PUBLISH} st_t;
  localparam int CH_PER_DEV = 2;
  function automatic int clog2(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin end
    return w;
  endfunction
  function automatic int ch_cs(input int ch);
    return ch / CH_PER_DEV;
  endfunction
  function automatic int ch_sel(input int ch);
    return ch % CH_PER_DEV;
  endfunction
endpackage

// File: rtl/adc_scan_seq_if.sv
// adc_scan_seq_if: converter handshake; master (sequencer) drives conv_start/conv_ch and takes conv_done/conv_data, slave (engine) is the reverse
interface adc_scan_seq_if #(parameter int NUM_CH = 3, parameter int DATA_W = 12);
  import adc_pkg::*;
  logic conv_start;
  logic [clog2(NUM_CH)-1:0] conv_ch;
  logic conv_done;
  logic [DATA_W-1:0] conv_data;
  modport master(output conv_start, conv_ch, input conv_done, conv_data);
  modport slave(input conv_start, conv_ch, output conv_done, conv_data);
endinterface

// File: rtl/adc_next_ch.sv
// adc_next_ch: priority finder; i_mask/i_idx (signed, -1 finds lowest) in, o_nxt = lowest set bit strictly above i_idx, o_none when there is none
module adc_next_ch import adc_pkg::*; #(
  parameter int N = 3,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0]      i_mask,
  input  logic signed [W:0] i_idx,
  output logic [W-1:0]      o_nxt,
  output logic              o_none
);
  always_comb begin
    o_nxt = '0;
    o_none = 1'b1;
    for (int j = N - 1; j >= 0; j--)
      if (i_mask[j] && j > int'(i_idx)) begin
        o_nxt = W'(j);
        o_none = 1'b0;
      end
  end
endmodule

// File: rtl/adc_scan_seq.sv
// adc_scan_seq: masked multi-channel ADC scan with 2^AVG_LOG2 averaging; clk/reset, ena/mode/start/ch_mask in, cv converter handshake, coordinates/frame_valid/busy/timeout_err out
module adc_scan_seq import adc_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ena,
  input  logic                     mode,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  adc_scan_seq_if.master           cv,
  output logic [NUM_CH*DATA_W-1:0] coordinates,
  output logic                     frame_valid,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int CHW = clog2(NUM_CH);
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int TW = clog2(TIMEOUT);
  localparam int CW = AVG_LOG2 + 1;
  localparam int NS = 1 << AVG_LOG2;
  st_t r_st, w_st;
  logic [NUM_CH-1:0] r_mask;
  logic [CHW-1:0] r_ch, w_lo, w_nx;
  logic w_lo_none, w_nx_none, w_done, w_last, w_tmo, w_load;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc, w_sum;
  logic [TW-1:0] r_tmr;
  logic [NUM_CH*DATA_W-1:0] r_sh;
  adc_next_ch #(.N(NUM_CH)) u_lo (.i_mask(ch_mask), .i_idx('1), .o_nxt(w_lo), .o_none(w_lo_none));
  adc_next_ch #(.N(NUM_CH)) u_nx (.i_mask(r_mask), .i_idx({1'b0, r_ch}), .o_nxt(w_nx), .o_none(w_nx_none));
  assign w_sum = r_acc + AW'(cv.conv_data);
  assign w_done = r_st == WAIT && cv.conv_done;
  assign w_last = r_cnt == CW'(NS - 1);
  assign w_tmo = r_st == WAIT && !cv.conv_done && r_tmr == TW'(TIMEOUT - 1);
  assign w_load = w_st == ISSUE && (r_st == IDLE || r_st == PUBLISH);
  assign cv.conv_start = r_st == ISSUE;
  assign cv.conv_ch = r_ch;
  assign busy = r_st != IDLE;
  always_comb begin
    w_st = r_st;
    case (r_st)
      IDLE:    w_st = ena && (mode || start) && !w_lo_none ? ISSUE : IDLE;
      ISSUE:   w_st = WAIT;
      WAIT:    w_st = !(w_done || w_tmo) ? WAIT : !ena ? IDLE : (w_done && !w_last) ? ISSUE : NEXT;
      NEXT:    w_st = w_nx_none ? PUBLISH : ISSUE;
      PUBLISH: w_st = ena && mode && !w_lo_none ? ISSUE : IDLE;
      default: w_st = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= IDLE;
      r_mask <= '0;
      r_ch <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_tmr <= '0;
      r_sh <= '0;
      coordinates <= '0;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_st <= w_st;
      frame_valid <= w_st == PUBLISH;
      if (w_st == PUBLISH) coordinates <= r_sh;
      if (w_load) begin
        r_mask <= ch_mask;
        r_ch <= w_lo;
        r_cnt <= '0;
        r_acc <= '0;
        if (r_st == IDLE && start) timeout_err <= 1'b0;
      end
      if (r_st == ISSUE) r_tmr <= '0;
      if (r_st == WAIT) r_tmr <= r_tmr + 1'b1;
      if (w_done) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_sh[int'(r_ch)*DATA_W +: DATA_W] <= DATA_W'(w_sum >> AVG_LOG2);
      end
      if (w_tmo) timeout_err <= 1'b1;
      if (r_st == NEXT) begin
        r_ch <= w_nx;
        r_cnt <= '0;
        r_acc <= '0;
      end
    end
  end
endmodule

// File: tb/tb_adc_scan_seq.sv
// tb_adc_scan_seq: table-driven frames with a conv_ch/coordinates scoreboard, behavioural engine of latency D, plus continuous, ena-drop and reset corner sequences
module tb_adc_scan_seq;
  localparam int NUM_CH = 3, DATA_W = 12, AVG_LOG2 = 2, TIMEOUT = 1023, D = 4;
  localparam int CW = NUM_CH * DATA_W;
  typedef struct {
    logic [2:0] mask;
    int hold, b0, b1, b2, s0, s1;
    logic [CW-1:0] exp;
    int lat, err, tcyc;
  } row_t;
  logic clk = 0, reset = 1, ena = 0, mode = 0, start = 0, fdone = 0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [CW-1:0] coordinates;
  logic frame_valid, busy, timeout_err;
  int checks = 0, errors = 0;
  int t = 0, e_ch = 0, hold = -1;
  int base[NUM_CH], step[NUM_CH], kc[NUM_CH];
  int q_ch[$];
  logic [CW-1:0] q_fr[$];
  row_t rows[4];
  logic [CW-1:0] full = {12'd4095, 12'd4000, 12'd101};
  adc_scan_seq_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) cv();
  adc_scan_seq #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ena(ena), .mode(mode), .start(start), .ch_mask(ch_mask), .cv(cv),
    .coordinates(coordinates), .frame_valid(frame_valid), .busy(busy), .timeout_err(timeout_err));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  initial begin
    cv.conv_done = 1'b0;
    cv.conv_data = '0;
    forever begin
      @(posedge clk); #1;
      cv.conv_done = fdone;
      if (t > 0) begin
        t--;
        if (t == 0) begin
          cv.conv_done = 1'b1;
          cv.conv_data = DATA_W'(base[e_ch] + step[e_ch] * (kc[e_ch] % 4));
          kc[e_ch]++;
        end
      end
      if (cv.conv_start && int'(cv.conv_ch) != hold) begin
        t = D;
        e_ch = int'(cv.conv_ch);
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk); #1;
      if (cv.conv_start) begin
        if (q_ch.size() == 0) begin
          checks++; errors++;
          $display("FAIL conv_start: unexpected request on ch %0d", cv.conv_ch);
        end else check("conv_ch", 64'(cv.conv_ch), 64'(q_ch.pop_front()));
      end
      if (frame_valid) begin
        if (q_fr.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_valid: unexpected frame 0x%0h", coordinates);
        end else check("coordinates", coordinates, q_fr.pop_front());
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic setup(input int h, input int b0, input int b1, input int b2, input int s0, input int s1);
    hold = h;
    base[0] = b0; base[1] = b1; base[2] = b2;
    step[0] = s0; step[1] = s1; step[2] = 0;
    for (int c = 0; c < NUM_CH; c++) kc[c] = 0;
  endtask
  task automatic push_frame(input logic [2:0] m, input int h, input logic [CW-1:0] e);
    for (int c = 0; c < NUM_CH; c++)
      if (m[c]) repeat (c == h ? 1 : 1 << AVG_LOG2) q_ch.push_back(c);
    q_fr.push_back(e);
  endtask
  task automatic wait_fv(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk); #1;
      start = 0;
      if (frame_valid) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic check_zero(input string nm);
    check({nm, "_coords"}, coordinates, 0);
    check({nm, "_frame_valid"}, frame_valid, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_timeout_err"}, timeout_err, 0);
    check({nm, "_conv_start"}, cv.conv_start, 0);
    check({nm, "_conv_ch"}, cv.conv_ch, 0);
  endtask
  task automatic run_row(input row_t r);
    int n;
    bit seen;
    ch_mask = r.mask;
    setup(r.hold, r.b0, r.b1, r.b2, r.s0, r.s1);
    push_frame(r.mask, r.hold, r.exp);
    start = 1;
    seen = 0;
    for (n = 1; n <= r.lat + 8; n++) begin
      @(posedge clk); #1;
      start = 0;
      if (r.tcyc != 0 && n == r.tcyc - 1) check("err_before_timeout", timeout_err, 0);
      if (r.tcyc != 0 && n == r.tcyc) check("err_at_timeout", timeout_err, 1);
      if (frame_valid) begin
        seen = 1;
        break;
      end
    end
    check("frame_latency", seen ? n : -1, r.lat);
    check("timeout_err", timeout_err, r.err);
    @(posedge clk); #1;
    check("frame_valid_pulse", frame_valid, 0);
    check("coords_hold", coordinates, r.exp);
    check("busy_after_frame", busy, 0);
  endtask
  initial begin
    int n;
    rows[0] = '{3'b111, -1, 100, 4000, 4095, 1, 0, {12'd4095, 12'd4000, 12'd101}, 64, 0, 0};
    rows[1] = '{3'b101, -1, 200, 0, 3000, 1, 0, {12'd3000, 12'd4000, 12'd201}, 43, 0, 0};
    rows[2] = '{3'b111, 1, 10, 0, 50, 0, 0, {12'd50, 12'd4000, 12'd10}, 1068, 1, 23 + TIMEOUT};
    rows[3] = '{3'b010, -1, 0, 7, 0, 0, 1, {12'd50, 12'd8, 12'd10}, 22, 0, 0};
    setup(-1, 0, 0, 0, 0, 0);
    repeat (4) begin
      @(posedge clk); #1;
      fdone = ~fdone;
    end
    fdone = 0;
    check_zero("reset");
    reset = 0;
    @(posedge clk); #1;
    check_zero("post_reset");
    ena = 1;
    ch_mask = '0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1 check("mask0_ignored_busy", busy, 0);
    for (int i = 0; i < 4; i++) run_row(rows[i]);
    ch_mask = 3'b111;
    setup(-1, 100, 4000, 4095, 1, 0);
    push_frame(3'b111, -1, full);
    push_frame(3'b111, -1, full);
    repeat (1 << AVG_LOG2) q_ch.push_back(0);
    q_ch.push_back(1);
    mode = 1;
    wait_fv(80, n);
    check("cont_first_latency", n, 64);
    wait_fv(80, n);
    check("cont_period", n, 64);
    for (int i = 1; i <= 27; i++) begin
      @(posedge clk); #1;
      if (i == 23) ena = 0;
      if (i == 26) check("ena_drop_busy_in_wait", busy, 1);
      if (i == 27) check("ena_drop_busy_fell", busy, 0);
    end
    n = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (frame_valid) n++;
    end
    check("ena_drop_no_frame", n, 0);
    check("ena_drop_coords", coordinates, full);
    mode = 0;
    ena = 1;
    setup(-1, 1, 1, 1, 0, 0);
    q_ch.push_back(0);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    check("wait_busy_before_reset", busy, 1);
    reset = 1;
    @(posedge clk); #1;
    check_zero("reset_in_wait");
    reset = 0;
    repeat (20) @(posedge clk);
    #1 check("late_done_ignored_busy", busy, 0);
    check("ch_queue_empty", q_ch.size(), 0);
    check("frame_queue_empty", q_fr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
